bus_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 64×8 program/data memory on the multiplexed address/data bus. It sits between the memory and two requesters: port 0 is the CPU core and port 1 is the console/loader. Each requester uses a simple req/ack handshake. The block grants the bus round-robin and drives the multiplexed ALE/En/Rw protocol: an address phase, then a data phase. Read data is returned per port.

---
 rtl/bus_arbiter_if.sv | 35 +++
 rtl/bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_bus_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Requester handshake and multiplexed memory bus signals shared by the
// arbiter (slave side) and the requesters plus memory (master side).
interface bus_arbiter_if #(
  parameter int W = 8
);
  logic         req0;
  logic         req1;
  logic         we0;
  logic         we1;
  logic [W-1:0] addr0;
  logic [W-1:0] addr1;
  logic [W-1:0] wdata0;
  logic [W-1:0] wdata1;
  logic         ack0;
  logic         ack1;
  logic [W-1:0] rdata0;
  logic [W-1:0] rdata1;
  logic [1:0]   gnt;
  logic         busy;
  logic [W-1:0] Bus_Out;
  logic [W-1:0] Bus_In;
  logic         ALE;
  logic         En;
  logic         Rw;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, Bus_In,
    output ack0, ack1, rdata0, rdata1, gnt, busy, Bus_Out, ALE, En, Rw
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, Bus_In,
    input  ack0, ack1, rdata0, rdata1, gnt, busy, Bus_Out, ALE, En, Rw
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-port round-robin arbiter and ALE/En/Rw sequencer for the shared
// program/data memory. Every output comes straight from a flop; the
// combinational block computes next-cycle output values from the next state.
//
//   state | meaning
//   IDLE  | no owner; arbitrate and capture the winner's request
//   ADDR  | ALE high, address on Bus_Out
//   DATA  | En high; memory performs the access at the ending edge
//   WAIT  | bus quiet; read data sampled from Bus_In at the ending edge
//   ACK   | one-cycle ack to the owner, bus outputs idle
module bus_arbiter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT, ACK} state_t;

  state_t       state, state_nx;
  logic         last, last_nx;
  logic         owner, owner_nx;
  logic         we_r, we_nx;
  logic [W-1:0] addr_r, addr_nx;
  logic [W-1:0] wdata_r, wdata_nx;
  logic [1:0]   gnt_r, gnt_nx;
  logic         busy_r, busy_nx;
  logic         ale_r, ale_nx;
  logic         en_r, en_nx;
  logic         rw_r, rw_nx;
  logic [W-1:0] bus_r, bus_nx;
  logic         ack0_r, ack0_nx;
  logic         ack1_r, ack1_nx;
  logic [W-1:0] rdata0_r, rdata0_nx;
  logic [W-1:0] rdata1_r, rdata1_nx;
  logic         win;

  // State, captured request and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      gnt_r    <= 2'b00;
      busy_r   <= 1'b0;
      ale_r    <= 1'b0;
      en_r     <= 1'b0;
      rw_r     <= 1'b1;
      bus_r    <= '0;
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      rdata0_r <= '0;
      rdata1_r <= '0;
    end else begin
      state    <= state_nx;
      last     <= last_nx;
      owner    <= owner_nx;
      we_r     <= we_nx;
      addr_r   <= addr_nx;
      wdata_r  <= wdata_nx;
      gnt_r    <= gnt_nx;
      busy_r   <= busy_nx;
      ale_r    <= ale_nx;
      en_r     <= en_nx;
      rw_r     <= rw_nx;
      bus_r    <= bus_nx;
      ack0_r   <= ack0_nx;
      ack1_r   <= ack1_nx;
      rdata0_r <= rdata0_nx;
      rdata1_r <= rdata1_nx;
    end
  end

  // Next state, arbitration and next-cycle output values
  always_comb begin
    state_nx  = state;
    last_nx   = last;
    owner_nx  = owner;
    we_nx     = we_r;
    addr_nx   = addr_r;
    wdata_nx  = wdata_r;
    gnt_nx    = gnt_r;
    ale_nx    = 1'b0;
    en_nx     = 1'b0;
    rw_nx     = 1'b1;
    bus_nx    = bus_r;
    ack0_nx   = 1'b0;
    ack1_nx   = 1'b0;
    rdata0_nx = rdata0_r;
    rdata1_nx = rdata1_r;
    // on a tie the port that did not win last time takes the bus
    win       = (bus.req0 && bus.req1) ? ~last : bus.req1;

    unique case (state)
      IDLE: begin
        gnt_nx = 2'b00;
        if (bus.req0 || bus.req1) begin
          state_nx = ADDR;
          owner_nx = win;
          last_nx  = win;
          we_nx    = win ? bus.we1    : bus.we0;
          addr_nx  = win ? bus.addr1  : bus.addr0;
          wdata_nx = win ? bus.wdata1 : bus.wdata0;
          gnt_nx   = win ? 2'b10 : 2'b01;
          ale_nx   = 1'b1;
          bus_nx   = win ? bus.addr1 : bus.addr0;
        end
      end
      ADDR: begin
        state_nx = DATA;
        en_nx    = 1'b1;
        rw_nx    = ~we_r;
        bus_nx   = we_r ? wdata_r : addr_r;
      end
      DATA: begin
        state_nx = WAIT;
      end
      WAIT: begin
        state_nx = ACK;
        bus_nx   = '0;
        ack0_nx  = ~owner;
        ack1_nx  = owner;
        if (!we_r) begin
          if (owner) rdata1_nx = bus.Bus_In;
          else       rdata0_nx = bus.Bus_In;
        end
      end
      ACK: begin
        state_nx = IDLE;
        gnt_nx   = 2'b00;
        bus_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = 2'b00;
        bus_nx   = '0;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  assign bus.ack0    = ack0_r;
  assign bus.ack1    = ack1_r;
  assign bus.rdata0  = rdata0_r;
  assign bus.rdata1  = rdata1_r;
  assign bus.gnt     = gnt_r;
  assign bus.busy    = busy_r;
  assign bus.Bus_Out = bus_r;
  assign bus.ALE     = ale_r;
  assign bus.En      = en_r;
  assign bus.Rw      = rw_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a 64x8 behavioural memory model.
module tb_bus_arbiter;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   overlap = 0;

  bus_arbiter_if #(.W(8)) bif ();

  bus_arbiter #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: latch address on ALE, write or read on En
  logic [7:0] mem [64];
  logic [5:0] mem_addr;
  logic       pre_we;
  logic [5:0] pre_a;
  logic [7:0] pre_d;

  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    if (bif.ALE) mem_addr <= bif.Bus_Out[5:0];
    if (bif.En && !bif.Rw) mem[mem_addr] <= bif.Bus_Out;
    if (bif.En && bif.Rw) bif.Bus_In <= mem[mem_addr];
  end

  always @(negedge clk) if (bif.ALE && bif.En) overlap++;

  typedef struct {
    logic       port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] exp_rd [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [5:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while (bif.busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (bif.busy) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic run_vec(input vec_t v);
    wait_idle();
    if (v.port) begin
      bif.we1 = v.we; bif.addr1 = v.addr; bif.wdata1 = v.wdata; bif.req1 = 1'b1;
    end else begin
      bif.we0 = v.we; bif.addr0 = v.addr; bif.wdata0 = v.wdata; bif.req0 = 1'b1;
    end
    @(posedge clk); #1;
    chk("c1_ale", bif.ALE, 1);
    chk("c1_bus", bif.Bus_Out, v.addr);
    chk("c1_gnt", bif.gnt, v.port ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    chk("c2_en", bif.En, 1);
    chk("c2_rw", bif.Rw, !v.we);
    chk("c2_bus", bif.Bus_Out, v.we ? v.wdata : v.addr);
    @(posedge clk); #1;
    chk("c3_en", bif.En, 0);
    @(posedge clk); #1;
    chk("c4_ack_own", v.port ? bif.ack1 : bif.ack0, 1);
    chk("c4_ack_oth", v.port ? bif.ack0 : bif.ack1, 0);
    if (!v.we) exp_rd[v.port] = v.exp_rdata;
    chk("c4_rdata0", bif.rdata0, exp_rd[0]);
    chk("c4_rdata1", bif.rdata1, exp_rd[1]);
    chk("c4_rw", bif.Rw, 1);
    bif.req0 = 1'b0; bif.req1 = 1'b0;
    @(posedge clk); #1;
    chk("c5_ack_gone", {bif.ack1, bif.ack0}, 2'b00);
    if (v.we) chk("mem_after_write", mem[v.addr[5:0]], v.wdata);
  endtask

  initial begin
    int         order [$];
    int         ack_t [$];
    int         n0, n1, dbl, alt_bad, p1_cnt, acks_seen;
    logic [1:0] pg, pa;

    rst = 1'b1; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    bif.req0 = 0; bif.req1 = 0; bif.we0 = 0; bif.we1 = 0;
    bif.addr0 = 0; bif.addr1 = 0; bif.wdata0 = 0; bif.wdata1 = 0;

    preload(6'h13, 8'h63);
    preload(6'h2A, 8'h3C);
    preload(6'h3F, 8'hF0);
    preload(6'h09, 8'h00);
    preload(6'h04, 8'h11);

    vecs[0] = '{1'b0, 1'b0, 8'h13, 8'h00, 8'h63};
    vecs[1] = '{1'b1, 1'b1, 8'h09, 8'hA5, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 8'h09, 8'h00, 8'hA5};
    vecs[3] = '{1'b0, 1'b1, 8'h3F, 8'h5A, 8'h00};
    vecs[4] = '{1'b0, 1'b0, 8'h3F, 8'h00, 8'h5A};
    vecs[5] = '{1'b1, 1'b0, 8'h2A, 8'h00, 8'h3C};
    vecs[6] = '{1'b0, 1'b0, 8'h53, 8'h00, 8'h63};

    // reset with both requests high
    bif.addr0 = 8'h13; bif.addr1 = 8'h2A;
    bif.req0 = 1'b1; bif.req1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", bif.gnt, 2'b00);
    chk("rst_busy", bif.busy, 0);
    chk("rst_ale", bif.ALE, 0);
    chk("rst_en", bif.En, 0);
    chk("rst_rw", bif.Rw, 1);
    chk("rst_bus", bif.Bus_Out, 8'h00);
    chk("rst_ack", {bif.ack1, bif.ack0}, 2'b00);
    chk("rst_rdata0", bif.rdata0, 8'h00);
    chk("rst_rdata1", bif.rdata1, 8'h00);
    rst = 1'b0;

    // tie out of reset, three transactions each
    n0 = 0; n1 = 0; dbl = 0; pg = 2'b00; pa = 2'b00;
    for (int cyc = 0; cyc < 60 && (n0 < 3 || n1 < 3); cyc++) begin
      @(posedge clk); #1;
      if (bif.gnt != 2'b00 && pg == 2'b00) order.push_back(bif.gnt == 2'b10 ? 1 : 0);
      pg = bif.gnt;
      if ((bif.ack0 && pa[0]) || (bif.ack1 && pa[1])) dbl++;
      pa = {bif.ack1, bif.ack0};
      if (bif.ack0 || bif.ack1) ack_t.push_back(cyc);
      if (bif.ack0) begin
        n0++;
        if (n0 >= 3) bif.req0 = 1'b0;
      end
      if (bif.ack1) begin
        n1++;
        if (n1 >= 3) bif.req1 = 1'b0;
      end
    end
    bif.req0 = 1'b0; bif.req1 = 1'b0;
    chk("tie_grants", order.size(), 6);
    for (int i = 0; i < order.size() && i < 6; i++) chk("tie_order", order[i], i % 2);
    chk("tie_acks", ack_t.size(), 6);
    for (int i = 1; i < ack_t.size(); i++) chk("tie_spacing", ack_t[i] - ack_t[i-1], 5);
    chk("tie_ack_width", dbl, 0);
    chk("tie_rdata0", bif.rdata0, 8'h63);
    chk("tie_rdata1", bif.rdata1, 8'h3C);
    exp_rd[0] = 8'h63; exp_rd[1] = 8'h3C;

    // table of single-port transactions
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // port 1 holds req, port 0 re-requests after each ack
    wait_idle();
    order.delete();
    bif.we0 = 0; bif.addr0 = 8'h13; bif.we1 = 0; bif.addr1 = 8'h2A;
    bif.req0 = 1'b1; bif.req1 = 1'b1;
    pg = 2'b00; acks_seen = 0;
    for (int cyc = 0; cyc < 80 && order.size() < 8; cyc++) begin
      @(posedge clk); #1;
      if (bif.gnt != 2'b00 && pg == 2'b00) order.push_back(bif.gnt == 2'b10 ? 1 : 0);
      pg = bif.gnt;
      if (bif.ack0) bif.req0 = 1'b0;
      else if (!bif.req0) bif.req0 = 1'b1;
    end
    bif.req0 = 1'b0; bif.req1 = 1'b0;
    alt_bad = 0; p1_cnt = 0;
    for (int i = 0; i < order.size(); i++) begin
      if (order[i] == 1) p1_cnt++;
      if (i > 0 && order[i] == order[i-1]) alt_bad++;
    end
    chk("starve_grants", order.size(), 8);
    chk("starve_alternate", alt_bad, 0);
    chk("starve_port1", p1_cnt, 4);

    // write aborted by reset in ADDR
    wait_idle();
    bif.we0 = 1'b1; bif.addr0 = 8'h04; bif.wdata0 = 8'h55; bif.req0 = 1'b1;
    @(posedge clk); #1;
    chk("abort_c1_ale", bif.ALE, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_en", bif.En, 0);
    chk("abort_busy", bif.busy, 0);
    chk("abort_gnt", bif.gnt, 2'b00);
    @(posedge clk); #1;
    chk("abort_en2", bif.En, 0);
    chk("abort_ack", bif.ack0, 0);
    chk("abort_mem", mem[4], 8'h11);
    rst = 1'b0;
    acks_seen = 0;
    for (int cyc = 0; cyc < 12 && acks_seen == 0; cyc++) begin
      @(posedge clk); #1;
      if (bif.ack0) acks_seen = 1;
    end
    bif.req0 = 1'b0;
    chk("retry_ack", acks_seen, 1);
    @(posedge clk); #1;
    chk("retry_mem", mem[4], 8'h55);

    chk("ale_en_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
